// File: rtl/reg_bus_master.sv
// Single-outstanding initiator for the GPIO/chip-info register bus; all outputs registered.
// Optional address rejection is enabled by defining REG_BUS_MASTER_ADDR_CHECK_EN.
module reg_bus_master #(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_r_wn,
    input  logic [2:0]  cmd_addr,
    input  logic [3:0]  cmd_wben,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [2:0]  bus_addr,
    output logic [3:0]  bus_wben,
    output logic        bus_r_wn,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    output logic [1:0]  fsm_state
);

    // Handshakes: a command transfers on a clk edge where cmd_valid & cmd_ready are both high;
    // a response transfers on a clk edge where rsp_valid & rsp_ready are both high.

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state, next;
    logic [2:0]  cnt, cnt_d;
    logic        reject;
    logic        cmd_ready_d, rsp_valid_d, rsp_err_d, bus_r_wn_d;
    logic [31:0] rsp_rdata_d, bus_wdata_d;
    logic [2:0]  bus_addr_d;
    logic [3:0]  bus_wben_d;

    assign fsm_state = state;

`ifdef REG_BUS_MASTER_ADDR_CHECK_EN
    always_comb begin
        reject = 1'b0;
        if (cmd_r_wn)
            reject = (cmd_addr == 3'd7);
        else
            reject = (cmd_addr == 3'd0) || (cmd_addr == 3'd1) ||
                     (cmd_addr == 3'd3) || (cmd_addr == 3'd7);
    end
`else
    assign reject = 1'b0;
`endif

    always_comb begin
        next        = state;
        cnt_d       = cnt;
        bus_addr_d  = bus_addr;
        bus_wben_d  = bus_wben;
        bus_r_wn_d  = bus_r_wn;
        bus_wdata_d = bus_wdata;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (reject) begin
                        next        = RESP;
                        rsp_rdata_d = 32'd0;
                        rsp_err_d   = 1'b1;
                    end else begin
                        next        = ISSUE;
                        rsp_err_d   = 1'b0;
                        bus_addr_d  = cmd_addr;
                        bus_r_wn_d  = cmd_r_wn;
                        bus_wben_d  = cmd_r_wn ? 4'd0 : cmd_wben;
                        bus_wdata_d = cmd_r_wn ? bus_wdata : cmd_wdata;
                    end
                end
            end
            ISSUE: begin
                // bus_r_wn low here means the current command is a write
                if (!bus_r_wn) begin
                    next        = RESP;
                    rsp_rdata_d = 32'd0;
                    bus_r_wn_d  = 1'b1;
                    bus_wben_d  = 4'd0;
                end else begin
                    next  = WAIT;
                    cnt_d = 3'(READ_LATENCY);
                end
            end
            WAIT: begin
                if (cnt == 3'd1) begin
                    next        = RESP;
                    rsp_rdata_d = bus_rdata;
                end else begin
                    cnt_d = cnt - 3'd1;
                end
            end
            RESP: begin
                if (rsp_ready)
                    next = IDLE;
            end
            default: next = IDLE;
        endcase
        cmd_ready_d = (next == IDLE);
        rsp_valid_d = (next == RESP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            bus_addr  <= 3'd0;
            bus_wben  <= 4'd0;
            bus_r_wn  <= 1'b1;
            bus_wdata <= 32'd0;
        end else begin
            state     <= next;
            cnt       <= cnt_d;
            cmd_ready <= cmd_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
            bus_addr  <= bus_addr_d;
            bus_wben  <= bus_wben_d;
            bus_r_wn  <= bus_r_wn_d;
            bus_wdata <= bus_wdata_d;
        end
    end

endmodule

// File: tb/tb_reg_bus_master.sv
// Directed bench for reg_bus_master with a small registered register-block model on the bus.
module tb_reg_bus_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_r_wn = 1'b1;
    logic [2:0]  cmd_addr = 3'd0;
    logic [3:0]  cmd_wben = 4'd0;
    logic [31:0] cmd_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [2:0]  bus_addr;
    logic [3:0]  bus_wben;
    logic        bus_r_wn;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata = 32'd0;
    logic [1:0]  fsm_state;

    reg_bus_master #(.READ_LATENCY(1)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_r_wn(cmd_r_wn),
        .cmd_addr(cmd_addr), .cmd_wben(cmd_wben), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .bus_addr(bus_addr), .bus_wben(bus_wben), .bus_r_wn(bus_r_wn),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .fsm_state(fsm_state)
    );

    // clock / cycle count
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // register block model: registered read data, byte-enabled write while r_wn is low
    logic [31:0] regs [8];
    int          wr_lows = 0;
    logic [3:0]  last_wben = 4'd0;
    initial begin
        for (int i = 0; i < 8; i++) regs[i] = 32'd0;
        regs[0] = 32'h48524A44;
    end
    always @(posedge clk) begin
        bus_rdata <= regs[bus_addr];
        if (!bus_r_wn) begin
            wr_lows   <= wr_lows + 1;
            last_wben <= bus_wben;
            if (bus_addr != 3'd0)
                for (int b = 0; b < 4; b++)
                    if (bus_wben[b]) regs[bus_addr][8*b +: 8] <= bus_wdata[8*b +: 8];
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic do_cmd(input logic r_wn, input logic [2:0] addr, input logic [3:0] wben,
                          input logic [31:0] wdata, output int acc_edge);
        int n;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_r_wn = r_wn; cmd_addr = addr; cmd_wben = wben; cmd_wdata = wdata;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("cmd_accept_timeout", 32'(cmd_ready), 32'd1);
        acc_edge = cyc + 1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int acc_edge, output int lat);
        int n;
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) check("rsp_timeout", 32'(rsp_valid), 32'd1);
        lat = cyc - acc_edge;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [2:0] addr, input logic [31:0] exp);
        int acc, lat;
        do_cmd(1'b1, addr, 4'd0, 32'd0, acc);
        wait_rsp(acc, lat);
        check({tag, "_rdata"}, rsp_rdata, exp);
        check({tag, "_err"}, 32'(rsp_err), 32'd0);
        check({tag, "_lat"}, 32'(lat), 32'd2);
        consume();
    endtask

    task automatic do_write(input string tag, input logic [2:0] addr, input logic [3:0] wben,
                            input logic [31:0] wdata);
        int acc, lat, w0;
        w0 = wr_lows;
        do_cmd(1'b0, addr, wben, wdata, acc);
        wait_rsp(acc, lat);
        check({tag, "_rdata"}, rsp_rdata, 32'd0);
        check({tag, "_err"}, 32'(rsp_err), 32'd0);
        check({tag, "_lat"}, 32'(lat), 32'd1);
        check({tag, "_low_cycles"}, 32'(wr_lows - w0), 32'd1);
        check({tag, "_wben"}, 32'(last_wben), 32'(wben));
        consume();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, lat, w0;
        logic [31:0] held;
        logic seen;

        // reset held for three edges
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_bus_r_wn", 32'(bus_r_wn), 32'd1);
        check("rst_bus_wben", 32'(bus_wben), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_bus_addr", 32'(bus_addr), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("post_rst_state", 32'(fsm_state), 32'd0);

        // chip id read
        do_read("rd_id", 3'd0, 32'h48524A44);

        // partial write to scratch, then read back
        do_write("wr_scratch", 3'd6, 4'b0101, 32'hDEADBEEF);
        do_read("rd_scratch", 3'd6, 32'h00AD00EF);

        // write with no byte enables still runs a bus cycle
        do_write("wr_nowben", 3'd6, 4'b0000, 32'hFFFFFFFF);
        do_read("rd_scratch2", 3'd6, 32'h00AD00EF);

        // response back-pressure
        do_cmd(1'b1, 3'd6, 4'd0, 32'd0, acc);
        wait_rsp(acc, lat);
        held = rsp_rdata;
        check("bp_first_rdata", held, 32'h00AD00EF);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_rdata !== held || cmd_ready || !bus_r_wn) seen = 1'b1;
        end
        check("bp_stable", 32'(seen), 32'd0);
        consume();
        check("bp_idle_state", 32'(fsm_state), 32'd0);
        check("bp_rsp_valid_low", 32'(rsp_valid), 32'd0);
        check("bp_cmd_ready", 32'(cmd_ready), 32'd1);

        // reset while waiting for read data
        do_cmd(1'b1, 3'd0, 4'd0, 32'd0, acc);
        @(negedge clk);
        check("mid_wait_state", 32'(fsm_state), 32'd2);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_state", 32'(fsm_state), 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_bus_r_wn", 32'(bus_r_wn), 32'd1);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check("mid_rst_no_rsp", 32'(seen), 32'd0);
        do_read("rd_after_rst", 3'd0, 32'h48524A44);

        // write to a read-only address
        w0 = wr_lows;
        do_cmd(1'b0, 3'd1, 4'b1111, 32'h12345678, acc);
        wait_rsp(acc, lat);
`ifdef REG_BUS_MASTER_ADDR_CHECK_EN
        check("wr_addr1_err", 32'(rsp_err), 32'd1);
        check("wr_addr1_low_cycles", 32'(wr_lows - w0), 32'd0);
`else
        check("wr_addr1_err", 32'(rsp_err), 32'd0);
        check("wr_addr1_low_cycles", 32'(wr_lows - w0), 32'd1);
`endif
        check("wr_addr1_rdata", rsp_rdata, 32'd0);
        check("wr_addr1_lat", 32'(lat), 32'd1);
        consume();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
